tart_capture_buffer: RTL and testbench

//  Acquisition-side sample store feeding the data-acquisition read-back unit (tart_aquire).
//  - Fill: captures one 24-bit antenna sample per valid strobe into block RAM.
//  - Drain: once full, serves words one at a time over the data_request/data_ready handshake.
//  - Generates the start/done flags that replace the fake-DRAM model used in SoC simulation.

---
 rtl/tart_capture_buffer.sv | 172 +++++++++++++++++
 tb/tb_tart_capture_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_capture_buffer.sv
// tart_capture_buffer: block-RAM sample store for the acquisition path.
// Samples (or a debug counter) fill the buffer through a programmable
// delay line; once full, words are drained one per request with a fixed
// two-cycle request-to-ready latency, then the buffer rearms.
module tart_capture_buffer #(
  parameter int WIDTH = 24,
  parameter int ABITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aq_enabled_i,
  input  logic             aq_debug_i,
  input  logic [2:0]       sample_delay_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_vld_i,
  input  logic             data_request_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             aq_start_o,
  output logic             aq_done_o,
  output logic [ABITS:0]   fill_count_o
);

  localparam int DEPTH = 2 ** ABITS;
  localparam int TAPS  = 8;
  localparam logic [ABITS:0] FILL_MAX = (ABITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Delay line: tap 0 is the live input, tap k is the input k cycles ago.
  // ---------------------------------------------------------------------
  logic [TAPS-1:0][WIDTH:0] tap_w;
  logic [2:0]               delay_q;
  logic [WIDTH:0]           tap_sel;
  logic                     tap_vld;
  logic [WIDTH-1:0]         tap_data;

  assign tap_w[0] = {sample_vld_i, sample_i};

  for (genvar gi = 1; gi < TAPS; gi++) begin : g_delay
    logic [WIDTH:0] stage_q;
    // Shift one stage of {strobe, sample} per clock.
    always_ff @(posedge clk) begin
      if (rst) stage_q <= '0;
      else     stage_q <= tap_w[gi-1];
    end
    assign tap_w[gi] = stage_q;
  end

  // Tap select is registered so a new delay setting applies from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) delay_q <= '0;
    else     delay_q <= sample_delay_i;
  end

  assign tap_sel  = tap_w[delay_q];
  assign tap_vld  = tap_sel[WIDTH];
  assign tap_data = tap_sel[WIDTH-1:0];

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  state_t           state_q;
  logic [ABITS-1:0] wptr_q;
  logic [ABITS-1:0] rptr_q;
  logic [WIDTH-1:0] dbg_cnt_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             pend_q;      // read issued, ready pulse due next cycle
  logic             all_read_q;  // every word of this block has been requested

  logic             wr_en_d;
  logic [WIDTH-1:0] wr_data_d;
  logic             rd_en_d;

  // Write/read strobes derived from the current state and inputs.
  always_comb begin
    wr_en_d   = (state_q == S_FILL) && aq_enabled_i && tap_vld;
    wr_data_d = aq_debug_i ? dbg_cnt_q : tap_data;
    rd_en_d   = (state_q == S_FULL) && data_request_i && !pend_q && !all_read_q;
  end

  // ---------------------------------------------------------------------
  // Sample memory: single write port, registered read port.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  // Memory write during FILL and registered read on an accepted request.
  always_ff @(posedge clk) begin
    if (wr_en_d) mem[wptr_q] <= wr_data_d;
    if (rd_en_d) rd_data_q   <= mem[rptr_q];
  end

  // Main FSM with registered outputs: fill, drain and rearm sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      dbg_cnt_q    <= '0;
      pend_q       <= 1'b0;
      all_read_q   <= 1'b0;
      data_ready_o <= 1'b0;
      data_o       <= '0;
      aq_start_o   <= 1'b0;
      aq_done_o    <= 1'b0;
      fill_count_o <= '0;
    end else begin
      aq_start_o   <= 1'b0;
      data_ready_o <= 1'b0;

      // Second pipeline stage of a read: present the word with its pulse.
      if (pend_q) begin
        pend_q       <= 1'b0;
        data_ready_o <= 1'b1;
        data_o       <= rd_data_q;
      end

      case (state_q)
        S_IDLE: begin
          if (aq_enabled_i) begin
            state_q      <= S_FILL;
            aq_start_o   <= 1'b1;
            wptr_q       <= '0;
            rptr_q       <= '0;
            dbg_cnt_q    <= '0;
            fill_count_o <= '0;
            all_read_q   <= 1'b0;
          end
        end

        S_FILL: begin
          if (!aq_enabled_i) begin
            // Abort: the partial block is discarded.
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            dbg_cnt_q    <= '0;
            fill_count_o <= '0;
          end else if (tap_vld) begin
            wptr_q    <= wptr_q + ABITS'(1);
            dbg_cnt_q <= dbg_cnt_q + WIDTH'(1);
            if (fill_count_o != FILL_MAX) fill_count_o <= fill_count_o + (ABITS + 1)'(1);
            if (&wptr_q) begin
              state_q   <= S_FULL;
              aq_done_o <= 1'b1;
            end
          end
        end

        S_FULL: begin
          if (data_ready_o && all_read_q) begin
            // Ready pulse of the last word is on the output now: rearm.
            state_q    <= S_IDLE;
            aq_done_o  <= 1'b0;
            all_read_q <= 1'b0;
          end else if (rd_en_d) begin
            pend_q <= 1'b1;
            rptr_q <= rptr_q + ABITS'(1);
            if (&rptr_q) all_read_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tart_capture_buffer.sv
// Self-checking bench for tart_capture_buffer (ABITS=4, 16-word blocks).
// A behavioural model built on queues and cycle-indexed history predicts
// every output each cycle; directed phases add literal expectations.
module tb_tart_capture_buffer;

  localparam int WIDTH = 24;
  localparam int ABITS = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             aq_enabled_i;
  logic             aq_debug_i;
  logic [2:0]       sample_delay_i;
  logic [WIDTH-1:0] sample_i;
  logic             sample_vld_i;
  logic             data_request_i;
  logic             data_ready_o;
  logic [WIDTH-1:0] data_o;
  logic             aq_start_o;
  logic             aq_done_o;
  logic [ABITS:0]   fill_count_o;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tart_capture_buffer #(.WIDTH(WIDTH), .ABITS(ABITS)) dut (
    .clk            (clk),
    .rst            (rst),
    .aq_enabled_i   (aq_enabled_i),
    .aq_debug_i     (aq_debug_i),
    .sample_delay_i (sample_delay_i),
    .sample_i       (sample_i),
    .sample_vld_i   (sample_vld_i),
    .data_request_i (data_request_i),
    .data_ready_o   (data_ready_o),
    .data_o         (data_o),
    .aq_start_o     (aq_start_o),
    .aq_done_o      (aq_done_o),
    .fill_count_o   (fill_count_o)
  );

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got_v, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               cyc = 8;
  logic [WIDTH:0]   hist [8];          // input seen in cycle c stored at c%8
  int               dly_m;             // delay in force this cycle
  int               mode;              // 0 idle, 1 filling, 2 holding a full block
  logic [WIDTH-1:0] words [$];         // words captured in the current block
  int               nread;             // words requested from the current block
  bit               pend;
  int               pend_due;
  logic [WIDTH-1:0] pend_val;
  logic             e_ready, e_start, e_done;
  logic [WIDTH-1:0] e_data;
  bit               model_valid = 0;
  logic [WIDTH-1:0] got [$];

  always @(posedge clk) begin : model
    logic [WIDTH:0] dl;
    bit accept;
    bit last_pulse;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      dly_m   = 0;
      mode    = 0;
      words.delete();
      nread   = 0;
      pend    = 0;
      e_ready = 0;
      e_start = 0;
      e_done  = 0;
      e_data  = '0;
      model_valid = 1;
    end else begin
      hist[cyc % 8] = {sample_vld_i, sample_i};
      dl    = hist[(cyc - dly_m) % 8];
      dly_m = int'(sample_delay_i);
      last_pulse = (mode == 2) && e_ready && (nread == DEPTH);
      accept     = (mode == 2) && data_request_i && !pend && (nread < DEPTH);
      e_start = 0;
      e_ready = 0;
      if (pend && pend_due == cyc + 1) begin
        e_ready = 1;
        e_data  = pend_val;
        pend    = 0;
      end
      if (accept) begin
        pend     = 1;
        pend_due = cyc + 2;
        pend_val = words[nread];
        nread++;
      end
      case (mode)
        0: if (aq_enabled_i) begin
          mode    = 1;
          e_start = 1;
          words.delete();
          nread   = 0;
        end
        1: if (!aq_enabled_i) begin
          mode = 0;
          words.delete();
        end else if (dl[WIDTH]) begin
          words.push_back(aq_debug_i ? WIDTH'(words.size()) : dl[WIDTH-1:0]);
          if (words.size() == DEPTH) mode = 2;
        end
        default: if (last_pulse) mode = 0;
      endcase
      e_done = (mode == 2);
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("ready", 32'(data_ready_o), 32'(e_ready));
      chk("data",  32'(data_o),       32'(e_data));
      chk("start", 32'(aq_start_o),   32'(e_start));
      chk("done",  32'(aq_done_o),    32'(e_done));
      chk("fill",  32'(fill_count_o), 32'(words.size()));
      if (data_ready_o === 1'b1) begin
        got.push_back(data_o);
        $display("read word %06h at %0t", data_o, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] t3_words [DEPTH];

  initial begin
    rst = 1'b1; aq_enabled_i = 1'b0; aq_debug_i = 1'b0; sample_delay_i = 3'd0;
    sample_i = '0; sample_vld_i = 1'b0; data_request_i = 1'b0;
    tick(); tick();
    chk("rst_done", 32'(aq_done_o), 32'h0);
    chk("rst_ready", 32'(data_ready_o), 32'h0);
    rst = 1'b0;

    // 1: enable -> start pulse
    aq_enabled_i = 1'b1;
    tick();
    chk("t1_start", 32'(aq_start_o), 32'h1);
    chk("t1_done", 32'(aq_done_o), 32'h0);
    chk("t1_fill", 32'(fill_count_o), 32'h0);

    // 2: debug counter fill and spaced drain
    aq_debug_i = 1'b1;
    sample_vld_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sample_i = WIDTH'($urandom);
      tick();
    end
    sample_vld_i = 1'b0;
    tick();
    chk("t2_done", 32'(aq_done_o), 32'h1);
    chk("t2_fill", 32'(fill_count_o), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      data_request_i = 1'b1;
      tick();
      data_request_i = 1'b0;
      chk("t2_ready_early", 32'(data_ready_o), 32'h0);
      tick();
      chk("t2_ready", 32'(data_ready_o), 32'h1);
      chk("t2_data", 32'(data_o), 32'(i));
      tick();
      tick();
    end
    chk("t2_rearm_start", 32'(aq_start_o), 32'h1);
    chk("t2_rearm_done", 32'(aq_done_o), 32'h0);
    aq_enabled_i = 1'b0;
    tick();

    // 3: delay of 3 cycles
    aq_debug_i = 1'b0;
    sample_delay_i = 3'd3;
    tick();
    aq_enabled_i = 1'b1;
    tick();
    sample_i = 24'hA5A5A5;
    sample_vld_i = 1'b1;
    t3_words[0] = 24'hA5A5A5;
    tick();
    sample_vld_i = 1'b0;
    sample_i = WIDTH'($urandom);
    tick();
    chk("t3_fill_t2", 32'(fill_count_o), 32'h0);
    tick();
    chk("t3_fill_t3", 32'(fill_count_o), 32'h0);
    tick();
    chk("t3_fill_t4", 32'(fill_count_o), 32'h1);
    for (int k = 1; k < DEPTH; k++) begin
      sample_i = WIDTH'($urandom);
      sample_vld_i = 1'b1;
      t3_words[k] = sample_i;
      tick();
    end
    sample_vld_i = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t3_done", 32'(aq_done_o), 32'h1);

    // 4: back-to-back requests -> one pulse, rptr +1
    got.delete();
    data_request_i = 1'b1;
    tick();
    tick();
    data_request_i = 1'b0;
    tick(); tick(); tick();
    chk("t4_pulses", 32'(got.size()), 32'h1);
    if (got.size() > 0) chk("t4_word0", 32'(got[0]), 32'hA5A5A5);
    data_request_i = 1'b1;
    tick();
    data_request_i = 1'b0;
    tick(); tick(); tick();
    chk("t4_pulses2", 32'(got.size()), 32'h2);
    if (got.size() > 1) chk("t4_word1", 32'(got[1]), 32'(t3_words[1]));

    // 5: abort a partial fill, then re-enable
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample_delay_i = 3'd0;
    aq_enabled_i = 1'b1;
    tick();
    chk("t5_start", 32'(aq_start_o), 32'h1);
    sample_vld_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_i = WIDTH'($urandom);
      tick();
    end
    sample_vld_i = 1'b0;
    chk("t5_fill5", 32'(fill_count_o), 32'h5);
    aq_enabled_i = 1'b0;
    tick();
    chk("t5_fill0", 32'(fill_count_o), 32'h0);
    chk("t5_done", 32'(aq_done_o), 32'h0);
    aq_enabled_i = 1'b1;
    tick();
    chk("t5_restart", 32'(aq_start_o), 32'h1);

    // 6: reset right after a request cancels the pulse
    sample_vld_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sample_i = WIDTH'($urandom);
      tick();
    end
    sample_vld_i = 1'b0;
    tick();
    chk("t6_done", 32'(aq_done_o), 32'h1);
    data_request_i = 1'b1;
    tick();
    data_request_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_ready", 32'(data_ready_o), 32'h0);
    chk("t6_data", 32'(data_o), 32'h0);
    chk("t6_done0", 32'(aq_done_o), 32'h0);
    chk("t6_fill", 32'(fill_count_o), 32'h0);
    rst = 1'b0;

    // Random phase: model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 599) == 0);
      aq_enabled_i   = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 99) == 0) aq_debug_i = ~aq_debug_i;
      if ($urandom_range(0, 49) == 0) sample_delay_i = 3'($urandom_range(0, 7));
      sample_i       = WIDTH'($urandom);
      sample_vld_i   = ($urandom_range(0, 2) != 0);
      data_request_i = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
